intadd_opnd_loader: RTL
=======================

# intadd_opnd_loader

- Operand-staging stage directly upstream of the 4-bit-lane saturating adder (add8).
- Receives the three 128-bit operands (src0, src1, src2) and their three sign-mode flags as a stream of 32-bit beats over a valid/ready interface.
- Assembles the beats into full-width registers and presents one complete operand set to the adder with a valid/ready handshake.
- The operand set is held stable until the consumer accepts it.

## Interface
- `BEAT_W`, default 32: input beat width in bits. Legal values are 32 only.
- `DATA_W`, default 128: operand width in bits. `DATA_W/BEAT_W` = 4 beats per operand.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset. Assertion is asynchronous; release must be synchronous to `clk`.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: loader can accept a beat.
- `in_data` input BEAT_W: beat payload.
- `in_sign` input 3: {sign_s2, sign_s1, sign_s0}. Sampled on beat 0 only.
- `in_par` input 1: even-parity bit over `in_data`. Used only when the macro is defined.
- `flush` input 1: synchronous abort of a partially loaded set.
- `op_valid` output 1: complete operand set is present.
- `op_ready` input 1: consumer accepts the set.
- `src0`, `src1`, `src2` output DATA_W each: assembled operands.
- `sign_s0`, `sign_s1`, `sign_s2` output 1 each: latched sign flags.
- `par_err` output 1: sticky parity error flag.

## Operation
- **Beat order (12 beats per set):**
  - Beats 0–3 go to `src0`, beats 4–7 to `src1`, beats 8–11 to `src2`.
  - Within an operand, beat k is written to bits [k*32 +: 32] (little-endian).
- **Counter:** `beat_cnt` is 4 bits, range 0..11. It increments on each accepted beat (`in_valid && in_ready`).
- **State machine:**
  - LOAD: `in_ready`=1.
    - Beat with `beat_cnt`==11 accepted → HOLD, `beat_cnt`←0.
  - HOLD: `in_ready`=0, `op_valid`=1.
    - `op_valid && op_ready` → LOAD.
- **Sign flags:** `in_sign` is captured into `sign_s*` when beat 0 is accepted. Flags stay unchanged on all other beats.
- **Operand registers:**
  - An operand register is written only by its own beats.
  - Registers are not cleared between sets; stale bits are overwritten by the next set's beats.
- **Flush:**
  - In LOAD: `beat_cnt`←0 and any beat presented in that cycle is dropped (not accepted, even though `in_ready`=1).
  - In HOLD: no effect; the held set is never discarded by `flush`.
- **Reset values:**
  - State is LOAD, `beat_cnt`=0.
  - `in_ready`=1, `op_valid`=0.
  - `src0`/`src1`/`src2`=0, `sign_s*`=0, `par_err`=0.
- **Reset mid-set:** the partial set is discarded, and the first beat after release is treated as beat 0.
- **Consumer side:** `op_valid` must not drop, and `src*`/`sign_s*` must not change, while `op_valid && !op_ready`.

## Timing
- The 12th beat is accepted at edge N. At edge N:
  - `op_valid` rises.
  - `src2[127:96]` holds the beat.
  - `in_ready` falls.
- Minimum input-to-`op_valid` latency is 1 cycle after the last beat. All outputs are registered.
- `op_ready` is sampled at edge M with `op_valid`=1:
  - After edge M, `op_valid`=0 and `in_ready`=1.
  - The earliest next beat is accepted at edge M+1.
- `in_ready` is a registered, state-decoded output. It has no combinational path from `op_ready` or `in_valid`.
- Sustained throughput is one set per 13 cycles with `op_ready` tied high.
- `flush` and `in_valid` in the same LOAD cycle: `flush` wins, no beat is accepted.

## Configuration
- **`INTADD_LDR_PARITY_EN` defined:**
  - On each accepted beat, the block computes `^in_data ^ in_par`.
  - A nonzero result sets `par_err`=1 at the next edge.
  - `par_err` is sticky until `rst`; the beat is still accepted and stored.
- **Not defined:** `in_par` is ignored and `par_err` is constant 0.

## Test plan
- **Basic load:**
  - Stimulus: 12 back-to-back beats 0x00000000..0x0000000B with `in_sign`=3'b101 on beat 0, `op_ready`=1.
  - Required: `src0`=0x00000003_00000002_00000001_00000000 and `src2[127:96]`=0x0000000B.
  - Required: `sign_s0`=1, `sign_s1`=0, `sign_s2`=1.
  - Required: `op_valid` high for exactly 1 cycle.
- **Backpressure:**
  - Stimulus: `op_ready`=0 for 5 cycles after `op_valid` rises, with `in_valid` held high.
  - Required: `in_ready`=0 throughout, outputs stable, no beat consumed.
  - Required: after `op_ready`, the next beat lands in `src0[31:0]`.
- **Flush:**
  - Stimulus: assert `flush` after 6 accepted beats (0xA0..0xA5), then send 12 beats 0xB0..0xBB.
  - Required: `src0[31:0]`=0xB0 and `src1[31:0]`=0xB4; the 0xA* values survive nowhere except bits later overwritten.
- **Mid-set reset:**
  - Stimulus: assert `rst` after beat 9.
  - Required: all outputs go to their reset values immediately (asynchronous), `in_ready`=1.
  - Required: a full 12-beat set after release yields a correct `op_valid`.
- **Parity (macro defined):**
  - Stimulus: beat 3 with `in_data`=0x00000001 and `in_par`=0.
  - Required: `par_err`=1 from the next edge, remaining high through two further sets.
  - Macro undefined, same stimulus: `par_err`=0.
- **Flush in HOLD:**
  - Stimulus: `flush`=1 while `op_valid`=1 and `op_ready`=0.
  - Required: `op_valid` stays 1 and `src*` unchanged.

Source files
------------

// File: rtl/intadd_opnd_loader_if.sv
// Bus between the beat producer, the operand loader and the add8 consumer.
interface intadd_opnd_loader_if #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic [2:0]        in_sign;
  logic              in_par;
  logic              flush;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] src0;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              sign_s0;
  logic              sign_s1;
  logic              sign_s2;
  logic              par_err;

  // Producer/consumer side of the bus.
  modport master (
    output in_valid, in_data, in_sign, in_par, flush, op_ready,
    input  in_ready, op_valid, src0, src1, src2, sign_s0, sign_s1, sign_s2, par_err
  );

  // Loader side of the bus.
  modport slave (
    input  in_valid, in_data, in_sign, in_par, flush, op_ready,
    output in_ready, op_valid, src0, src1, src2, sign_s0, sign_s1, sign_s2, par_err
  );
endinterface

// File: rtl/intadd_opnd_loader.sv
// Stages three DATA_W operands plus sign flags from a BEAT_W beat stream for add8.
// Optional beat parity checking is enabled by defining INTADD_LDR_PARITY_EN.
module intadd_opnd_loader #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned DATA_W = 128
) (
  input logic                 clk,
  input logic                 rst,
  intadd_opnd_loader_if.slave bus
);

  localparam int unsigned BEATS_PER_OP  = DATA_W / BEAT_W;
  localparam int unsigned BEATS_PER_SET = 3 * BEATS_PER_OP;
  localparam int unsigned CNT_W         = $clog2(BEATS_PER_SET);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_SET - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0] beat_q [BEATS_PER_SET];
  logic              in_ready_q;
  logic              op_valid_q;
  logic [2:0]        sign_q;
  logic              par_err_q;
  logic              par_bad_c;

`ifdef INTADD_LDR_PARITY_EN
  assign par_bad_c = (^bus.in_data) ^ bus.in_par;
`else
  logic unused_par;
  assign unused_par = bus.in_par;
  assign par_bad_c  = 1'b0;
`endif

  // Flush wins over a same-cycle beat; the held set in HOLD ignores flush entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      beat_cnt   <= '0;
      in_ready_q <= 1'b1;
      op_valid_q <= 1'b0;
      sign_q     <= '0;
      par_err_q  <= 1'b0;
      for (int unsigned i = 0; i < BEATS_PER_SET; i++) begin
        beat_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.flush) begin
            beat_cnt <= '0;
          end else if (bus.in_valid) begin
            beat_q[beat_cnt] <= bus.in_data;
            if (beat_cnt == '0) begin
              sign_q <= bus.in_sign;
            end
            if (par_bad_c) begin
              par_err_q <= 1'b1;
            end
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt   <= '0;
              state      <= ST_HOLD;
              in_ready_q <= 1'b0;
              op_valid_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.op_ready) begin
            state      <= ST_LOAD;
            in_ready_q <= 1'b1;
            op_valid_q <= 1'b0;
          end
        end
        default: begin
          state      <= ST_LOAD;
          in_ready_q <= 1'b1;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Beat k of an operand occupies bits [k*BEAT_W +: BEAT_W].
  for (genvar k = 0; k < BEATS_PER_OP; k++) begin : g_lane
    assign bus.src0[k*BEAT_W +: BEAT_W] = beat_q[k];
    assign bus.src1[k*BEAT_W +: BEAT_W] = beat_q[BEATS_PER_OP + k];
    assign bus.src2[k*BEAT_W +: BEAT_W] = beat_q[2*BEATS_PER_OP + k];
  end

  assign bus.in_ready = in_ready_q;
  assign bus.op_valid = op_valid_q;
  assign bus.sign_s0  = sign_q[0];
  assign bus.sign_s1  = sign_q[1];
  assign bus.sign_s2  = sign_q[2];
  assign bus.par_err  = par_err_q;

endmodule
